// File: rtl/prior_encoder_latched.sv
// Latched priority encoder: captures rising edges on N request lines as sticky
// pending bits and grants one at a time on a registered out/flag pair until acked.
module prior_encoder_latched #(
  parameter int N           = 4,
  parameter int OUT_W       = $clog2(N),
  parameter int ROUND_ROBIN = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N-1:0]     in,
  input  logic             ack,
  output logic [OUT_W-1:0] out,
  output logic             flag,
  output logic [N-1:0]     pending,
  output logic             overrun
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     in_q;
  logic [N-1:0]     pending_q, pending_d;
  logic [N-1:0]     rise, clr;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] ptr_q, ptr_d;
  logic [OUT_W-1:0] sel_start, sel;
  logic             overrun_q, overrun_d;
  logic             accept;

  // Scan downward from start-1, wrapping, and return the first set index.
  function automatic logic [OUT_W-1:0] select_req(input logic [N-1:0]     req,
                                                  input logic [OUT_W-1:0] start);
    logic [OUT_W-1:0] pick;
    logic [N-1:0]     sh;
    logic             found;
    int               idx;
    pick  = '0;
    found = 1'b0;
    for (int s = 1; s <= N; s++) begin
      idx = int'(start) - s;
      if (idx < 0) idx += N;
      sh = req >> idx;
      if (!found && sh[0]) begin
        pick  = OUT_W'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  always_comb begin
    rise      = in & ~in_q;
    accept    = (state_q == GRANT) && ack && enable;
    clr       = accept ? (N'(1) << out_q) : '0;
    pending_d = (pending_q & ~clr) | rise;
    overrun_d = overrun_q | (|(rise & pending_q & ~clr));
    sel_start = (ROUND_ROBIN != 0) ? ptr_q : '0;
    sel       = select_req(pending_q, sel_start);
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (enable && (|pending_q)) begin
          state_d = GRANT;
          out_d   = sel;
        end
      end
      GRANT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (ack) begin
          state_d = IDLE;
          ptr_d   = out_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_q tracks the inputs through reset so lines held high never count as edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      out_q     <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      overrun_q <= 1'b0;
      in_q      <= in;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      in_q      <= in;
    end
  end

  assign out     = out_q;
  assign flag    = (state_q == GRANT);
  assign pending = pending_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_prior_encoder_latched.sv
// Bench for prior_encoder_latched: three instances (N=4 fixed, N=4 round-robin,
// N=8 fixed) checked every cycle against a behavioural model plus directed literals.
module tb_prior_encoder_latched;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] in0, in1;
  logic [7:0] in2;
  logic en0, en1, en2, ack0, ack1, ack2;
  logic [1:0] out0, out1;
  logic [2:0] out2;
  logic flag0, flag1, flag2, ovr0, ovr1, ovr2;
  logic [3:0] pend0, pend1;
  logic [7:0] pend2;

  int errors = 0;
  int checks = 0;
  bit started = 0;

  always #5 clk = ~clk;

  prior_encoder_latched #(.N(4), .ROUND_ROBIN(0)) d0 (
    .clk(clk), .reset(reset), .enable(en0), .in(in0), .ack(ack0),
    .out(out0), .flag(flag0), .pending(pend0), .overrun(ovr0));
  prior_encoder_latched #(.N(4), .ROUND_ROBIN(1)) d1 (
    .clk(clk), .reset(reset), .enable(en1), .in(in1), .ack(ack1),
    .out(out1), .flag(flag1), .pending(pend1), .overrun(ovr1));
  prior_encoder_latched #(.N(8), .ROUND_ROBIN(0)) d2 (
    .clk(clk), .reset(reset), .enable(en2), .in(in2), .ack(ack2),
    .out(out2), .flag(flag2), .pending(pend2), .overrun(ovr2));

  // Model state, one slot per instance.
  bit [7:0] m_pend[3];
  bit [7:0] m_prev[3];
  bit       m_ovr[3];
  bit       m_flag[3];
  int       m_out[3];
  int       m_ptr[3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  task automatic model_tick(input int k, input int n, input bit rr, input bit [7:0] inp,
                            input bit en, input bit ak, input bit rs);
    bit [7:0] np;
    bit       acc, e, found;
    int       start, idx;
    if (rs) begin
      m_pend[k] = '0; m_ovr[k] = 0; m_flag[k] = 0;
      m_out[k] = 0; m_ptr[k] = 0; m_prev[k] = inp;
      return;
    end
    acc = m_flag[k] && en && ak;
    np  = m_pend[k];
    for (int i = 0; i < n; i++) begin
      e = inp[i] && !m_prev[k][i];
      if (acc && m_out[k] == i) np[i] = e;
      else                      np[i] = m_pend[k][i] | e;
      if (e && m_pend[k][i] && !(acc && m_out[k] == i)) m_ovr[k] = 1;
    end
    if (m_flag[k]) begin
      if (!en) m_flag[k] = 0;
      else if (ak) begin
        m_flag[k] = 0;
        m_ptr[k]  = m_out[k];
      end
    end else if (en && m_pend[k] != 0) begin
      start = rr ? m_ptr[k] : 0;
      found = 0;
      for (int s = 1; s <= n; s++) begin
        idx = (start - s + n) % n;
        if (!found && m_pend[k][idx]) begin
          m_out[k]  = idx;
          m_flag[k] = 1;
          found     = 1;
        end
      end
    end
    m_pend[k] = np;
    m_prev[k] = inp;
  endtask

  always @(posedge clk) begin
    model_tick(0, 4, 0, {4'b0, in0}, en0, ack0, reset);
    model_tick(1, 4, 1, {4'b0, in1}, en1, ack1, reset);
    model_tick(2, 8, 0, in2, en2, ack2, reset);
    started = 1;
  end

  task automatic cmp_inst(input int k, input logic f, input logic [2:0] o,
                          input logic [7:0] p, input logic ov);
    chk($sformatf("model_d%0d_flag", k), {31'b0, f}, {31'b0, m_flag[k]});
    chk($sformatf("model_d%0d_out", k), {29'b0, o}, m_out[k]);
    chk($sformatf("model_d%0d_pending", k), {24'b0, p}, {24'b0, m_pend[k]});
    chk($sformatf("model_d%0d_overrun", k), {31'b0, ov}, {31'b0, m_ovr[k]});
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, flag0, {1'b0, out0}, {4'b0, pend0}, ovr0);
      cmp_inst(1, flag1, {1'b0, out1}, {4'b0, pend1}, ovr1);
      cmp_inst(2, flag2, out2, pend2, ovr2);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int o;
    int exp2[3];
    int exp3[5];
    exp2 = '{3, 1, 0};
    exp3 = '{3, 2, 1, 0, 3};
    reset = 1; in0 = 4'b0100; in1 = '0; in2 = '0;
    en0 = 1; en1 = 1; en2 = 1; ack0 = 0; ack1 = 0; ack2 = 0;
    step(); step();
    reset = 0;
    step();
    chk("t1_no_pending_after_reset", {28'b0, pend0}, 32'h0);
    chk("t1_no_flag_after_reset", {31'b0, flag0}, 32'h0);

    // single request, grant, ack
    in0 = 4'b0110; step();
    chk("t1_pending_e0", {28'b0, pend0}, 32'h2);
    chk("t1_flag_e0", {31'b0, flag0}, 32'h0);
    step();
    chk("t1_flag_e1", {31'b0, flag0}, 32'h1);
    chk("t1_out_e1", {30'b0, out0}, 32'd1);
    ack0 = 1; step();
    chk("t1_flag_after_ack", {31'b0, flag0}, 32'h0);
    chk("t1_pending_after_ack", {28'b0, pend0}, 32'h0);
    ack0 = 0;

    // three simultaneous edges drained in fixed priority order
    in0 = 4'b0000; step();
    in0 = 4'b1011; step();
    chk("t2_pending", {28'b0, pend0}, 32'hB);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_flag_%0d", i), {31'b0, flag0}, 32'h1);
      chk($sformatf("t2_out_%0d", i), {30'b0, out0}, exp2[i]);
      ack0 = 1; step();
      chk($sformatf("t2_gap_%0d", i), {31'b0, flag0}, 32'h0);
      ack0 = 0; step();
    end
    chk("t2_pending_end", {28'b0, pend0}, 32'h0);
    chk("t2_flag_end", {31'b0, flag0}, 32'h0);

    // round robin with all lines kept pending
    in1 = 4'hF; step();
    chk("t3_pending", {28'b0, pend1}, 32'hF);
    step();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_flag_%0d", i), {31'b0, flag1}, 32'h1);
      chk($sformatf("t3_out_%0d", i), {30'b0, out1}, exp3[i]);
      o = int'(out1);
      ack1 = 1; in1[o] = 1'b0; step();
      chk($sformatf("t3_gap_%0d", i), {31'b0, flag1}, 32'h0);
      ack1 = 0; in1[o] = 1'b1; step();
    end
    chk("t3_no_overrun", {31'b0, ovr1}, 32'h0);

    // ack while disabled/idle must not move the rotation pointer
    en1 = 0; step();
    chk("t6_rr_withdrawn", {31'b0, flag1}, 32'h0);
    ack1 = 1; step(); step();
    chk("t6_rr_pending_kept", {28'b0, pend1}, 32'hF);
    ack1 = 0; en1 = 1; step();
    chk("t6_rr_flag", {31'b0, flag1}, 32'h1);
    chk("t6_rr_out_ptr_unmoved", {30'b0, out1}, 32'd2);

    // N=8: edges captured while disabled, grant withdrawn by enable drop
    en2 = 0; in2 = 8'h84; step(); step();
    chk("t4_pending_disabled", {24'b0, pend2}, 32'h84);
    chk("t4_flag_disabled", {31'b0, flag2}, 32'h0);
    en2 = 1; step();
    chk("t4_flag", {31'b0, flag2}, 32'h1);
    chk("t4_out", {29'b0, out2}, 32'd7);
    en2 = 0; step();
    chk("t4_withdrawn", {31'b0, flag2}, 32'h0);
    chk("t4_pending_kept", {24'b0, pend2}, 32'h84);
    en2 = 1; step();
    chk("t4_regrant_out", {29'b0, out2}, 32'd7);
    ack2 = 1; step();
    chk("t4_pending_after_ack", {24'b0, pend2}, 32'h04);
    ack2 = 0; step();
    chk("t4_out_second", {29'b0, out2}, 32'd2);
    ack2 = 1; step();
    ack2 = 0;
    chk("t4_pending_end", {24'b0, pend2}, 32'h0);

    // clear/rise collision, then a true overrun
    in0 = 4'b0000; step();
    in0 = 4'b0010; step(); step();
    chk("t5_out", {30'b0, out0}, 32'd1);
    in0 = 4'b0000; step();
    in0 = 4'b0010; ack0 = 1; step();
    chk("t5_collision_pending", {28'b0, pend0}, 32'h2);
    chk("t5_collision_overrun", {31'b0, ovr0}, 32'h0);
    chk("t5_collision_flag", {31'b0, flag0}, 32'h0);
    ack0 = 0; step();
    chk("t5_regrant_flag", {31'b0, flag0}, 32'h1);
    chk("t5_regrant_out", {30'b0, out0}, 32'd1);
    in0 = 4'b0000; step();
    in0 = 4'b0010; step();
    chk("t5_overrun_set", {31'b0, ovr0}, 32'h1);
    step();
    chk("t5_overrun_sticky", {31'b0, ovr0}, 32'h1);

    // reset mid-grant clears everything on that edge
    reset = 1; step();
    chk("t6_reset_flag", {31'b0, flag0}, 32'h0);
    chk("t6_reset_out", {30'b0, out0}, 32'h0);
    chk("t6_reset_pending", {28'b0, pend0}, 32'h0);
    chk("t6_reset_overrun", {31'b0, ovr0}, 32'h0);
    reset = 0; step();
    ack0 = 1; step();
    chk("t6_idle_ack_pending", {28'b0, pend0}, 32'h0);
    chk("t6_idle_ack_flag", {31'b0, flag0}, 32'h0);
    ack0 = 0; step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prior_encoder_latched.md
# prior_encoder_latched

Parametrised, clocked successor to the team's 4-input combinational priority encoder (`out`/`flag`/`enable`). The block captures rising edges on `N` request lines into sticky pending bits and grants the highest-priority pending request on a registered `out`/`flag` pair. The grant holds until the consumer acknowledges it. It supports fixed (MSB-highest) or round-robin arbitration and reports lost edges. It sits between raw event/interrupt sources and a single sequential consumer.

## Interface
- `N`, default 4: number of request lines, N ≥ 2.
- `OUT_W`, default `$clog2(N)`: width of `out`. Derived; do not override.
- `ROUND_ROBIN`, default 0: 0 = fixed priority (highest index wins); 1 = rotating priority.
- Reset is synchronous and active-high. The block uses one clock.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `enable` in 1: when low, no new grant is issued and an active grant is withdrawn.
- `in` in N: request lines, level inputs. Only 0→1 transitions are events.
- `ack` in 1: consumer acknowledge. Meaningful only while `flag`=1.
- `out` out OUT_W: index of the granted request. Registered.
- `flag` out 1: grant valid. Registered.
- `pending` out N: sticky pending-request register.
- `overrun` out 1: sticky. Set when an edge arrives on a line whose pending bit is already set.

## Operation
- Edge detect: `in_q` is a registered copy of `in`; `rise = in & ~in_q`.
- During reset, `in_q` loads `in`, so a line held high through reset produces no event.
- Pending update every edge: `pending <= (pending & ~clr) | rise`.
  - `clr` = one-hot(`out`) when `flag & ack & enable`, else 0.
  - If `rise` and `clr` hit the same bit, the bit stays set; `rise` wins.
- Overrun: `overrun <= overrun | |(rise & pending & ~clr)`. It clears only on reset.
- Edges are captured regardless of `enable`.
- State machine, 2 states:
  - IDLE (`flag`=0):
    - If `enable` and registered `pending` ≠ 0 → GRANT, with `out` = selected index.
    - Otherwise stay in IDLE; `out` holds its last value.
  - GRANT (`flag`=1, `out` frozen):
    - If `enable`=0 → IDLE. Pending is untouched.
    - Else if `ack` → IDLE and clear `pending[out]`.
    - Else stay in GRANT.
- Selection:
  - Fixed mode: highest set index of `pending`.
  - Round-robin mode: search indices `ptr-1, ptr-2, …, 0, N-1, …, ptr` (mod N) and take the first set bit.
  - `ptr` (OUT_W bits) loads `out` on every accepted ack.
  - `ptr` reset = 0, so the first search order is N-1 down to 0, identical to fixed mode.
- Selection uses only the registered `pending`. Same-cycle `rise` is not considered.
- `ack` in IDLE, or with `enable`=0, is ignored. Nothing is cleared and `ptr` does not move.

## Timing
- Reset values: `out`=0, `flag`=0, `pending`=0, `overrun`=0, `ptr`=0, state IDLE.
- Reset mid-grant drops `flag` on the same edge and discards all pending requests.
- Latency:
  - `in` rises before edge E0 → `pending` bit set at E0.
  - `flag`=1 and `out` valid at E1, provided `enable`=1 and the block is in IDLE.
- Handshake:
  - `ack` is sampled at the edge where `flag`=1.
  - That edge drops `flag` and clears the bit.
  - The next grant appears at the following edge at the earliest. There is always ≥1 cycle of `flag`=0 between grants.
- `out` is stable for the whole time `flag`=1.
- An `enable` drop during GRANT → `flag`=0 at the next edge. The request is re-granted once `enable` returns, subject to re-arbitration.

## Test plan
1. N=4, fixed: reset with `in`=4'b0100 held → no pending, `flag`=0. Then raise `in[1]` → `pending`=0010 at E0, `flag`=1 / `out`=1 at E1. `ack` → `flag`=0, `pending`=0.
2. N=4, fixed: rising edges on `in`=1011 in one cycle → grants in order `out`=3, 1, 0, one per ack. `flag`=0 for one cycle between grants. `pending` ends at 0.
3. N=4, `ROUND_ROBIN`=1: hold `pending`=1111 by re-pulsing each line after its ack → grant sequence 3, 2, 1, 0, 3.
4. N=8: `enable`=0 while edges arrive on lines 7 and 2 → `pending`=1000_0100, `flag`=0. Set `enable`=1 → `out`=7 next edge. Drop `enable` during the grant → `flag`=0, pending unchanged.
5. Clear/rise collision: during a grant on line 1, line 1 pulses low then high so that `rise[1]` coincides with `ack` → `pending[1]` stays 1, `overrun`=0, and line 1 is re-granted. A second edge on a line that is already pending → `overrun`=1 until reset.
6. `ack` asserted while `flag`=0 → no change to `pending` or `ptr`. Reset asserted while `flag`=1 → all outputs 0 at that edge.
